branch_predictor: RTL and testbench

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Feeds the prediction that travels down the pipe with each instruction and arrives at the ALU as EX_BP_taken / EX_BP_target_pc.
- Trained one cycle later from the ALU's resolved outcome (true taken, computed target, flush).
- Sits between the PC register and the IF/ID pipeline register.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/bp_sat_ctr.sv | 12 +
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// default geometry, BTB entry layout and the saturating counter update.
package bp_pkg;

  localparam int BP_PC_BITS  = 12;
  localparam int BP_ENTRIES  = 16;
  localparam int BP_IDX_BITS = $clog2(BP_ENTRIES);
  localparam int BP_TAG_BITS = BP_PC_BITS - BP_IDX_BITS - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Entry layout for the default geometry.
  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_PC_BITS-1:0]  target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr,
                                                input logic       taken);
    sat_ctr_update = ctr;
    if (taken) begin
      if (ctr != CTR_ST) sat_ctr_update = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) sat_ctr_update = ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/EX-side bundle for the branch predictor; master is the pipeline,
// slave is the predictor.
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int PC_BITS = BP_PC_BITS
);
  // No backpressure: EX_brn is the only qualifier and marks one resolved
  // branch per cycle; the predictor always accepts it and F_* is always valid.
  logic [PC_BITS-1:0] F_pc;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic               EX_brn;
  logic [PC_BITS-1:0] EX_pc;
  logic               EX_true_taken;
  logic [PC_BITS-1:0] EX_target_pc;
  logic               EX_taken;
  logic [31:0]        BP_branch_cnt;
  logic [31:0]        BP_mispredict_cnt;

  modport master (
    output F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    input  F_BP_taken, F_BP_target_pc, BP_branch_cnt, BP_mispredict_cnt
  );

  modport slave (
    input  F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    output F_BP_taken, F_BP_target_pc, BP_branch_cnt, BP_mispredict_cnt
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a 2-bit saturating direction counter.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  assign ctr_next = sat_ctr_update(ctr, taken);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, trained from EX.
// Optional resolved-branch / mispredict statistics under `BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_BITS = BP_PC_BITS,
  parameter int ENTRIES = BP_ENTRIES
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = PC_BITS - IDX_BITS - 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_BITS-1:0]  target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  // Lookup reads only flopped state, so an update in the same cycle is not
  // visible until the next one.
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;
  logic                f_pred_taken;

  assign f_idx        = bp.F_pc[IDX_BITS+1:2];
  assign f_tag        = bp.F_pc[PC_BITS-1:IDX_BITS+2];
  assign f_hit        = table_q[f_idx].valid && (table_q[f_idx].tag == f_tag);
  assign f_pred_taken = f_hit && table_q[f_idx].ctr[1];

  assign bp.F_BP_taken     = f_pred_taken;
  assign bp.F_BP_target_pc = f_pred_taken ? table_q[f_idx].target
                                          : bp.F_pc + PC_BITS'(4);

  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic [1:0]          ctr_upd;

  assign ex_idx = bp.EX_pc[IDX_BITS+1:2];
  assign ex_tag = bp.EX_pc[PC_BITS-1:IDX_BITS+2];
  assign ex_hit = table_q[ex_idx].valid && (table_q[ex_idx].tag == ex_tag);

  bp_sat_ctr u_sat_ctr (
    .ctr      (table_q[ex_idx].ctr),
    .taken    (bp.EX_true_taken),
    .ctr_next (ctr_upd)
  );

  // Training ignores EX_taken: a flushed branch still resolved for real.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (bp.EX_brn) begin
      if (ex_hit) begin
        table_q[ex_idx].ctr <= ctr_upd;
        if (bp.EX_true_taken) table_q[ex_idx].target <= bp.EX_target_pc;
      end else if (bp.EX_true_taken) begin
        table_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag,
                             target: bp.EX_target_pc, ctr: CTR_WT};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bp.EX_brn) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (bp.EX_taken && (mispredict_cnt_q != 32'hFFFF_FFFF))
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign bp.BP_branch_cnt     = branch_cnt_q;
  assign bp.BP_mispredict_cnt = mispredict_cnt_q;
`else
  assign bp.BP_branch_cnt     = '0;
  assign bp.BP_mispredict_cnt = '0;
`endif

  // Byte-offset bits never select an entry; EX_taken only feeds the stats.
  logic unused_ok;
  assign unused_ok = ^{bp.EX_pc[1:0], bp.EX_taken};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table model.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int PC_BITS  = 12;
  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;
  localparam int MASK     = (1 << PC_BITS) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_BITS(PC_BITS)) bp_if ();

  branch_predictor #(.PC_BITS(PC_BITS), .ENTRIES(ENTRIES)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one record per direct-mapped slot, plain ints.
  int m_valid  [ENTRIES];
  int m_tag    [ENTRIES];
  int m_target [ENTRIES];
  int m_ctr    [ENTRIES];
  int m_branches;
  int m_misp;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_misp     = 0;
  endfunction

  function automatic void model_predict(input int pc, output logic t, output int tgt);
    int idx, tg;
    idx = (pc / 4) % ENTRIES;
    tg  = pc / (4 * ENTRIES);
    t   = (m_valid[idx] != 0) && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
    tgt = t ? m_target[idx] : ((pc + 4) & MASK);
  endfunction

  function automatic void model_update(input int pc, input logic taken,
                                       input int tgt, input logic flush);
    int idx, tg;
    idx = (pc / 4) % ENTRIES;
    tg  = pc / (4 * ENTRIES);
    if (m_valid[idx] != 0 && m_tag[idx] == tg) begin
      if (taken) begin
        m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
    m_branches++;
    if (flush) m_misp++;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pred(input string tag);
    logic et;
    int   etg;
    model_predict(int'(bp_if.F_pc), et, etg);
    check_val({tag, "_taken"}, 32'(bp_if.F_BP_taken), 32'(et));
    check_val({tag, "_target"}, 32'(bp_if.F_BP_target_pc), 32'(etg));
  endtask

  task automatic check_stats(input string tag);
    int eb, em;
`ifdef BP_STATS_EN
    eb = m_branches; em = m_misp;
`else
    eb = 0; em = 0;
`endif
    check_val({tag, "_brcnt"}, bp_if.BP_branch_cnt, 32'(eb));
    check_val({tag, "_mpcnt"}, bp_if.BP_mispredict_cnt, 32'(em));
  endtask

  // Directed constant expectation for the current F_pc, before the edge.
  task automatic expect_pred(input string tag, input logic t, input int tgt);
    #1;
    check_val({tag, "_taken"}, 32'(bp_if.F_BP_taken), 32'(t));
    check_val({tag, "_target"}, 32'(bp_if.F_BP_target_pc), 32'(tgt));
  endtask

  // Check against the model, take one edge, then advance the model.
  task automatic tick(input string tag);
    #1;
    check_pred(tag);
    check_stats(tag);
    @(posedge clk);
    if (rst) model_reset();
    else if (bp_if.EX_brn)
      model_update(int'(bp_if.EX_pc), bp_if.EX_true_taken,
                   int'(bp_if.EX_target_pc), bp_if.EX_taken);
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic brn, input int pc, input logic taken,
                          input int tgt, input logic flush);
    bp_if.EX_brn        = brn;
    bp_if.EX_pc         = PC_BITS'(pc);
    bp_if.EX_true_taken = taken;
    bp_if.EX_target_pc  = PC_BITS'(tgt);
    bp_if.EX_taken      = flush;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    tick("reset");
    rst = 1'b0;
  endtask

  function automatic int rand_pc();
    int tg_sel, tg;
    tg_sel = $urandom_range(0, 2);
    tg = (tg_sel == 0) ? 0 : (tg_sel == 1) ? 1 : 63;
    return (tg << (IDX_BITS + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    model_reset();
    rst = 1'b1;
    bp_if.F_pc = '0;
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    do_reset();
    check_stats("after_reset");

    // Cold table: fall-through prediction, including wrap at the top.
    bp_if.F_pc = 12'h100;
    expect_pred("cold_100", 1'b0, 'h104);
    tick("cold_100");
    bp_if.F_pc = 12'hFFC;
    expect_pred("cold_ffc", 1'b0, 'h000);
    tick("cold_ffc");

    // Allocate 0x100 -> 0x040.
    bp_if.F_pc = 12'h100;
    drive_ex(1'b1, 'h100, 1'b1, 'h040, 1'b1);
    tick("alloc");
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    expect_pred("alloc_hit", 1'b1, 'h040);
    tick("alloc_hit");

    // Saturate to strong taken, then walk back down.
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 'h100, 1'b1, 'h040, 1'b0);
      tick("train_t");
    end
    drive_ex(1'b1, 'h100, 1'b0, 'h104, 1'b1);
    tick("train_nt1");
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    expect_pred("after_nt1", 1'b1, 'h040);
    drive_ex(1'b1, 'h100, 1'b0, 'h104, 1'b1);
    tick("train_nt2");
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    expect_pred("after_nt2", 1'b0, 'h104);
    tick("after_nt2");

    // Aliasing: 0x500 shares the slot of 0x100 with a different tag.
    drive_ex(1'b1, 'h100, 1'b1, 'h040, 1'b0);
    tick("realloc");
    drive_ex(1'b1, 'h500, 1'b1, 'h2A0, 1'b0);
    tick("alias");
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    bp_if.F_pc = 12'h100;
    expect_pred("alias_100", 1'b0, 'h104);
    tick("alias_100");
    bp_if.F_pc = 12'h500;
    expect_pred("alias_500", 1'b1, 'h2A0);
    tick("alias_500");

    // Same-cycle update and lookup: no bypass.
    do_reset();
    bp_if.F_pc = 12'h100;
    drive_ex(1'b1, 'h100, 1'b1, 'h040, 1'b0);
    expect_pred("same_cyc", 1'b0, 'h104);
    tick("same_cyc");
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    expect_pred("same_next", 1'b1, 'h040);
    tick("same_next");

    // Stats: five branches, two flagged as mispredicts, then reset clears.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_ex(1'b1, 'h200 + 4 * i, i[0], 'h300, (i == 0 || i == 2));
      tick("stats_br");
    end
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
`ifdef BP_STATS_EN
    check_val("stats_5_br", bp_if.BP_branch_cnt, 32'd5);
    check_val("stats_2_mp", bp_if.BP_mispredict_cnt, 32'd2);
`else
    check_val("stats_off_br", bp_if.BP_branch_cnt, 32'd0);
    check_val("stats_off_mp", bp_if.BP_mispredict_cnt, 32'd0);
`endif
    tick("stats_hold");

    // Reset beats a concurrent allocating update.
    rst = 1'b1;
    drive_ex(1'b1, 'h200, 1'b1, 'h3F0, 1'b1);
    tick("rst_win");
    rst = 1'b0;
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    bp_if.F_pc = 12'h200;
    expect_pred("rst_win_200", 1'b0, 'h204);
    check_val("rst_win_brcnt", bp_if.BP_branch_cnt, 32'd0);
    tick("rst_win_200");

    // Random traffic over a small set of aliasing tags.
    for (int n = 0; n < 400; n++) begin
      bp_if.F_pc = PC_BITS'(rand_pc());
      drive_ex(($urandom_range(0, 3) != 0), rand_pc(), $urandom_range(0, 1),
               $urandom_range(0, MASK), $urandom_range(0, 1));
      tick("rand");
    end
    drive_ex(1'b0, 0, 1'b0, 0, 1'b0);
    tick("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
